mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle MIPS multiply/divide unit that owns the HI/LO registers.
- Sits in the execute stage next to the ALU and executes mult, multu, div and divu.
- Reuses one instance of the existing 32-bit flag-producing adder once per cycle: add for multiply, subtract for divide.
- The control unit stalls the pipeline while busy is high; mfhi/mflo read the hi/lo outputs directly.

Parameters:
- WIDTH, 32, operand width; only 32 is supported.
- ITER, 32, iterations per operation; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  00 multu, 01 mult, 10 divu, 11 div.
- a_in  in  32  multiplicand or dividend (rs).
- b_in  in  32  multiplier or divisor (rt).
- hi_we  in  1  mthi write enable.
- lo_we  in  1  mtlo write enable.
- wdata  in  32  mthi/mtlo data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when hi/lo are updated by an operation.
- div_by_zero  out  1  valid with done; set for a div/divu with b_in==0.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (asynchronous, active-high, may arrive mid-operation): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; iteration counter and operand registers cleared; any in-flight operation is abandoned.
- States: IDLE, PREP, RUN, FIX.
  - IDLE→PREP on start. Latch op, a_in, b_in; busy<=1.
  - PREP→RUN after 1 cycle.
    - Signed ops: record result sign. Quotient/product sign = sign(a)^sign(b); remainder sign = sign(a).
    - Signed ops: replace operands by their magnitudes, using in-block two's-complement negation (not the adder).
    - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
    - Counter<=0.
  - RUN: one iteration per edge, 32 edges; RUN→FIX after the iteration with counter==31.
  - FIX→IDLE after 1 cycle.
    - Apply sign correction: 64-bit negate of the product; independent 32-bit negate of quotient and remainder.
    - Write hi/lo; done<=1 for exactly one cycle; busy<=0.
- Multiply iteration (adder a_in=acc_hi, b_in=lsb(mplier)?mcand:0, cin=0): {acc_hi,acc_lo}<={carry,O_out,acc_lo[31:1]}. The multiplier is shifted in the acc_lo register. Final HI=acc_hi, LO=acc_lo.
- Divide iteration (restoring):
  - Shift {rem,quot} left by 1.
  - Adder a_in=shifted rem, b_in=~divisor, cin=1.
  - Subtraction succeeds if the bit shifted out of rem is 1 or carry=1. On success rem<=O_out and the quotient lsb<=1; otherwise rem is kept and the lsb<=0.
  - Final HI=rem, LO=quot.
- Latency:
  - start is sampled at edge E0.
  - RUN iterations occur at E2..E33.
  - hi/lo are updated and done rises at E34.
  - Fixed 34 cycles for every op, including divide by zero.
- Divide by zero: the datapath runs normally, then FIX overrides the result: HI=original a_in, LO=0xFFFFFFFF, div_by_zero=1 with done. No sign correction is applied, for both div and divu.
- div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0, div_by_zero=0.
- start while busy: ignored, no queuing.
- hi_we/lo_we:
  - In IDLE, write on the next edge.
  - While busy, ignored.
  - Simultaneous with start in IDLE, the write is applied and start is also accepted; the FIX write later overwrites it.
- div_by_zero holds its value until the next done.
- hi/lo are stable except at FIX, during mthi/mtlo, or on reset.

Decomposition:
- Shared CPU package: MD_OP_MULTU/MULT/DIVU/DIV encodings and state encoding localparams.
- Sub-module: the existing adder (ports a_in, b_in, cin, O_out, zero, carry, overflow, negative), instantiated once.
  - zero, overflow and negative are unused.
- All other logic is in mult_div_unit.

Test Plan:
- multu 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done exactly 34 cycles after start; busy high for cycles 1–34.
- mult 0xFFFFFFFF×0x00000002 → HI=0xFFFFFFFF, LO=0xFFFFFFFE; mult 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- div 0xFFFFFFF9(−7)/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 → LO=3, HI=1; div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- divu 5/0 → HI=5, LO=0xFFFFFFFF, div_by_zero=1; the next multu 3×4 → HI=0, LO=12, div_by_zero=0.
- start pulsed at cycle 5 of a running op, plus hi_we with wdata=0x1234 while busy → both ignored; result matches the first op only. mthi 0x1234 in IDLE → hi=0x1234 next cycle.
- rst asserted asynchronously at cycle 10 of a div → immediately busy=0, done=0, hi=lo=0; a new start after release completes normally in 34 cycles.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the two's-complement helpers used for sign handling.
package mult_div_unit_pkg;

  localparam logic [1:0] MD_OP_MULTU = 2'b00;
  localparam logic [1:0] MD_OP_MULT  = 2'b01;
  localparam logic [1:0] MD_OP_DIVU  = 2'b10;
  localparam logic [1:0] MD_OP_DIV   = 2'b11;

  localparam logic [1:0] MD_ST_IDLE = 2'd0;
  localparam logic [1:0] MD_ST_PREP = 2'd1;
  localparam logic [1:0] MD_ST_RUN  = 2'd2;
  localparam logic [1:0] MD_ST_FIX  = 2'd3;

  typedef enum logic [1:0] {
    StIdle = MD_ST_IDLE,
    StPrep = MD_ST_PREP,
    StRun  = MD_ST_RUN,
    StFix  = MD_ST_FIX
  } md_state_e;

  function automatic logic [31:0] md_neg(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // 0x80000000 maps onto itself and is then read as an unsigned magnitude.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? md_neg(v) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_adder.sv
// Flag-producing ripple adder shared by the execute stage; O_out = a_in + b_in + cin.
module mult_div_unit_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic [WIDTH-1:0] O_out,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, cin};
  end

  assign O_out    = w_sum[WIDTH-1:0];
  assign carry    = w_sum[WIDTH];
  assign zero     = (w_sum[WIDTH-1:0] == '0);
  assign negative = w_sum[WIDTH-1];
  assign overflow = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (w_sum[WIDTH-1] != a_in[WIDTH-1]);

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS mult/multu/div/divu engine owning HI/LO; one add or subtract
// per cycle through the shared adder, fixed 34-cycle latency from start to done.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CntW = $clog2(ITER);
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);
  localparam logic [2*WIDTH-1:0] ProdOne = {{(2*WIDTH-1){1'b0}}, 1'b1};

  md_state_e        r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_mcand;
  logic [CntW-1:0]  r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_is_div;
  logic             w_prep_signed;
  logic [WIDTH-1:0] w_rem_sh;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_add_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_sub_ok;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic             w_unused_zero;
  logic             w_unused_ovf;
  logic             w_unused_neg;

  assign w_is_div      = r_op[1];
  assign w_prep_signed = r_op[0];

  // Divide: remainder picks up the quotient register's msb on each shift.
  assign w_rem_sh  = {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
  assign w_add_a   = w_is_div ? w_rem_sh : r_acc_hi;
  assign w_add_b   = w_is_div ? ~r_mcand : (r_acc_lo[0] ? r_mcand : '0);
  assign w_add_cin = w_is_div;
  assign w_sub_ok  = r_acc_hi[WIDTH-1] | w_carry;

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_neg = ~w_prod + ProdOne;

  mult_div_unit_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a_in    (w_add_a),
    .b_in    (w_add_b),
    .cin     (w_add_cin),
    .O_out   (w_sum),
    .zero    (w_unused_zero),
    .carry   (w_carry),
    .overflow(w_unused_ovf),
    .negative(w_unused_neg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_op     <= MD_OP_MULTU;
      r_a      <= '0;
      r_b      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_op    <= op;
            r_a     <= a_in;
            r_b     <= b_in;
            r_busy  <= 1'b1;
            r_state <= StPrep;
          end
        end
        StPrep: begin
          r_neg_q  <= w_prep_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r  <= w_prep_signed & r_a[WIDTH-1];
          r_acc_hi <= '0;
          if (w_is_div) begin
            r_acc_lo <= md_abs(r_a, w_prep_signed);
            r_mcand  <= md_abs(r_b, w_prep_signed);
          end else begin
            r_acc_lo <= md_abs(r_b, w_prep_signed);
            r_mcand  <= md_abs(r_a, w_prep_signed);
          end
          r_cnt   <= '0;
          r_state <= StRun;
        end
        StRun: begin
          if (w_is_div) begin
            r_acc_hi <= w_sub_ok ? w_sum : w_rem_sh;
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_sub_ok};
          end else begin
            {r_acc_hi, r_acc_lo} <= {w_carry, w_sum, r_acc_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == CntLast) r_state <= StFix;
        end
        StFix: begin
          if (w_is_div && (r_mcand == '0)) begin
            // Divide by zero: report original dividend, no sign correction.
            r_hi  <= r_a;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else if (w_is_div) begin
            r_hi  <= r_neg_r ? md_neg(r_acc_hi) : r_acc_hi;
            r_lo  <= r_neg_q ? md_neg(r_acc_lo) : r_acc_lo;
            r_dbz <= 1'b0;
          end else begin
            {r_hi, r_lo} <= r_neg_q ? w_prod_neg : w_prod;
            r_dbz        <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests;
  int n_fail;

  mult_div_unit #(
    .WIDTH(32),
    .ITER (32)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a_in       (a_in),
    .b_in       (b_in),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns edges elapsed since the start edge and cycles with busy seen high.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz);
    int lat;
    int bc;
    launch(o, a, b);
    wait_done(lat, bc);
    check_eq({tag, "_lat"}, 64'(lat), 64'd34);
    check_eq({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check_eq({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    check_eq({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
  endtask

  initial begin
    int lat;
    int bc;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    a_in    = '0;
    b_in    = '0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    wdata   = '0;

    @(posedge clk);
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // multu with latency and busy-window checks
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    check_eq("multu_max_lat", 64'(lat), 64'd34);
    check_eq("multu_max_busy", 64'(bc), 64'd34);
    check_eq("multu_max_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    check_eq("multu_max_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);
    check_eq("multu_busy_end", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    check_eq("done_pulse", {63'd0, done}, 64'd0);

    run_op("mult_m1x2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("mult_min2", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7_2", 2'b10, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0);
    run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu_5_0", 2'b10, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("dbz_hold", {63'd0, div_by_zero}, 64'd1);
    run_op("multu_3x4", 2'b00, 32'h3, 32'h4, 32'h0, 32'd12, 1'b0);

    // start and mthi while busy must both be ignored
    launch(2'b00, 32'd7, 32'd6);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    a_in  = 32'd100;
    b_in  = 32'd3;
    hi_we = 1'b1;
    wdata = 32'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    wait_done(lat, bc);
    check_eq("busy_ign_done", {63'd0, done}, 64'd1);
    check_eq("busy_ign_hi", {32'd0, hi}, 64'd0);
    check_eq("busy_ign_lo", {32'd0, lo}, 64'd42);
    repeat (2) @(posedge clk);
    #1;
    check_eq("no_queue_busy", {63'd0, busy}, 64'd0);

    // mthi / mtlo in IDLE
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h1234;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    check_eq("mthi", {32'd0, hi}, 64'h1234);
    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'h5678;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check_eq("mtlo", {32'd0, lo}, 64'h5678);
    check_eq("mtlo_hi_kept", {32'd0, hi}, 64'h1234);

    // asynchronous reset in the middle of a divide
    launch(2'b11, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", {63'd0, busy}, 64'd0);
    check_eq("arst_done", {63'd0, done}, 64'd0);
    check_eq("arst_hi", {32'd0, hi}, 64'd0);
    check_eq("arst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("divu_after_rst", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
